vga_image_engine: RTL

//  Parametrised VGA scan-out engine: timing generator, image-window address generator for a

---
 rtl/vga_image_engine.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_image_engine.sv
// vga_image_engine
//   VGA scan-out engine.
//   - A pixel-rate clock enable (pix_en) is derived from clk_50MHz by a divider.
//   - Column and row counters produce hsync/vsync and the active area.
//   - An image-window address generator drives a synchronous pixel ROM.
//   - An RGB/sync output pipeline is latency-matched to the ROM.
//
//   Image placement, scale and display mode are shadowed at the start of each
//   frame, so changing them mid-frame never tears the picture.
//
// Ports
//   clk_50MHz   in   system clock
//   rst_n       in   synchronous reset, active-low
//   mode        in   0 blank, 1 image, 2 colour bars, 3 solid BG_RGB
//   img_x/img_y in   window left column / top row
//   scale_log2  in   image magnification is 2^scale_log2
//   rom_addr    out  ROM read address (holds its value outside the window)
//   rom_dout    in   ROM pixel {r,g,b}, valid ROM_LAT pix_en after rom_addr
//   vga_red/green/blue, vga_hsync/vsync  out  board pins
//   frame_start out  one-clock pulse marking the pix_en of pixel (0,0)
//
// Pipeline: stage 1 (address + flags), ROM_LAT flag delay stages, then the
// output register. The pins therefore lag the counters by ROM_LAT+2 pix_en.
module vga_image_engine #(
  parameter int         H_ACTIVE = 640,
  parameter int         H_FP     = 16,
  parameter int         H_SYNC   = 96,
  parameter int         H_BP     = 48,
  parameter int         V_ACTIVE = 480,
  parameter int         V_FP     = 10,
  parameter int         V_SYNC   = 2,
  parameter int         V_BP     = 33,
  parameter logic       SYNC_POL = 1'b0,
  parameter int         CLK_DIV  = 2,
  parameter int         IMG_W    = 256,
  parameter int         IMG_H    = 256,
  parameter int         ADDR_W   = 16,
  parameter int         ROM_LAT  = 1,
  parameter logic [2:0] BG_RGB   = 3'b000
) (
  input  logic              clk_50MHz,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [9:0]        img_x,
  input  logic [9:0]        img_y,
  input  logic [1:0]        scale_log2,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_dout,
  output logic [2:0]        vga_red,
  output logic [2:0]        vga_green,
  output logic [1:0]        vga_blue,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(IMG_W);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Per-pixel attributes carried alongside the ROM access.
  typedef struct packed {
    logic       active;
    logic       in_win;
    logic       hs;
    logic       vs;
    logic [1:0] mode;
    logic [2:0] bar;
  } flags_t;

  logic [DW-1:0]     div_q, div_d;
  logic [10:0]       col_q, col_d, row_q, row_d;
  logic [9:0]        sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  logic [1:0]        sh_s_q, sh_s_d, sh_mode_q, sh_mode_d;
  flags_t            st_q [0:ROM_LAT];
  flags_t            st_d [0:ROM_LAT];
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [2:0]        rgb_q, rgb_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              fs_q, fs_d;

  logic              pix_en, at_origin;
  logic [9:0]        cur_x, cur_y;
  logic [1:0]        cur_s, cur_mode;
  logic [11:0]       dx, dy;
  logic [10:0]       dxs, dys;
  logic              in_x, in_y;
  logic [31:0]       win_addr, bar_full;
  flags_t            f_new, f_out;
  logic [2:0]        colour;

  assign pix_en    = (div_q == DW'(CLK_DIV - 1));
  assign at_origin = (col_q == 11'd0) && (row_q == 11'd0);

  // Pixel (0,0) is the pixel at which the shadow registers reload, so it uses
  // the live inputs. Every other pixel uses the values held for this frame.
  assign cur_x    = at_origin ? img_x      : sh_x_q;
  assign cur_y    = at_origin ? img_y      : sh_y_q;
  assign cur_s    = at_origin ? scale_log2 : sh_s_q;
  assign cur_mode = at_origin ? mode       : sh_mode_q;

  // 12-bit subtraction: bit 11 is the borrow, set when the pixel is left of or
  // above the window.
  assign dx   = {1'b0, col_q} - {2'b00, cur_x};
  assign dy   = {1'b0, row_q} - {2'b00, cur_y};
  assign dxs  = dx[10:0] >> cur_s;
  assign dys  = dy[10:0] >> cur_s;
  assign in_x = !dx[11] && (32'(dxs) < IMG_W) && (32'(col_q) < H_ACTIVE);
  assign in_y = !dy[11] && (32'(dys) < IMG_H) && (32'(row_q) < V_ACTIVE);

  assign win_addr = (32'(dys) << XW) + 32'(dxs);
  assign bar_full = (32'(col_q) * 32'd8) / 32'(H_ACTIVE);

  always_comb begin
    f_new.active = (32'(col_q) < H_ACTIVE) && (32'(row_q) < V_ACTIVE);
    f_new.in_win = in_x && in_y;
    f_new.hs     = (32'(col_q) >= 32'(H_ACTIVE + H_FP)) &&
                   (32'(col_q) <  32'(H_ACTIVE + H_FP + H_SYNC));
    f_new.vs     = (32'(row_q) >= 32'(V_ACTIVE + V_FP)) &&
                   (32'(row_q) <  32'(V_ACTIVE + V_FP + V_SYNC));
    f_new.mode   = cur_mode;
    f_new.bar    = bar_full[2:0];
  end

  // Colour is chosen in the output stage, where rom_dout for this pixel is valid.
  assign f_out = st_q[ROM_LAT];

  always_comb begin
    colour = 3'b000;
    case (f_out.mode)
      2'd1:    colour = f_out.in_win ? rom_dout : BG_RGB;
      2'd2:    colour = f_out.bar;
      2'd3:    colour = BG_RGB;
      default: colour = 3'b000;
    endcase
    if (!f_out.active) colour = 3'b000;
  end

  always_comb begin
    div_d      = div_q;
    col_d      = col_q;
    row_d      = row_q;
    sh_x_d     = sh_x_q;
    sh_y_d     = sh_y_q;
    sh_s_d     = sh_s_q;
    sh_mode_d  = sh_mode_q;
    st_d       = st_q;
    rom_addr_d = rom_addr_q;
    rgb_d      = rgb_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    fs_d       = pix_en && at_origin;

    if (pix_en) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end

    if (pix_en) begin
      if (32'(col_q) == H_TOTAL - 1) begin
        col_d = 11'd0;
        if (32'(row_q) == V_TOTAL - 1) row_d = 11'd0;
        else                           row_d = row_q + 11'd1;
      end else begin
        col_d = col_q + 11'd1;
      end

      if (at_origin) begin
        sh_x_d    = img_x;
        sh_y_d    = img_y;
        sh_s_d    = scale_log2;
        sh_mode_d = mode;
      end

      if (f_new.in_win) rom_addr_d = win_addr[ADDR_W-1:0];

      st_d[0] = f_new;
      for (int i = 1; i <= ROM_LAT; i++) st_d[i] = st_q[i-1];

      rgb_d   = colour;
      hsync_d = f_out.hs ? SYNC_POL : ~SYNC_POL;
      vsync_d = f_out.vs ? SYNC_POL : ~SYNC_POL;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      div_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      sh_x_q     <= img_x;
      sh_y_q     <= img_y;
      sh_s_q     <= scale_log2;
      sh_mode_q  <= mode;
      for (int i = 0; i <= ROM_LAT; i++) st_q[i] <= '0;
      rom_addr_q <= '0;
      rgb_q      <= 3'b000;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      fs_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      col_q      <= col_d;
      row_q      <= row_d;
      sh_x_q     <= sh_x_d;
      sh_y_q     <= sh_y_d;
      sh_s_q     <= sh_s_d;
      sh_mode_q  <= sh_mode_d;
      for (int i = 0; i <= ROM_LAT; i++) st_q[i] <= st_d[i];
      rom_addr_q <= rom_addr_d;
      rgb_q      <= rgb_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      fs_q       <= fs_d;
    end
  end

  // A 1-bit colour is replicated across each pin group so "on" is full scale.
  assign vga_red     = {3{rgb_q[2]}};
  assign vga_green   = {3{rgb_q[1]}};
  assign vga_blue    = {2{rgb_q[0]}};
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign rom_addr    = rom_addr_q;
  assign frame_start = fs_q;

endmodule
